// File: rtl/float16_pkg.sv
// Shared half-precision constants and the accumulator FSM state type.
// Imported by the accumulator and its alignment shifter.
package float16_pkg;

  localparam int EXP_BIAS = 15;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;

  localparam logic [14:0] MAX_MAG = 15'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    OUT
  } state_t;

endpackage

// File: rtl/float_align_shift.sv
// Combinational right barrel shifter; shifts of W or more flush to zero.
// Ports: din (mantissa), sh (shift amount), dout (aligned mantissa).
module float_align_shift
  import float16_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0]     din,
  input  logic [EXP_W-1:0] sh,
  output logic [W-1:0]     dout
);

  always_comb begin
    if (int'(sh) >= W) dout = '0;
    else               dout = din >> sh;
  end

endmodule

// File: rtl/float_accum.sv
// Sequential half-precision accumulator: align, add, normalize, output.
// Ports: clk/rst/clear, in_* operand handshake, out_* result handshake.
module float_accum
  import float16_pkg::*;
#(
  parameter int GUARD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int W = MANT_W + 1 + GUARD_BITS;

  state_t state, state_nx;

  logic [15:0]      op;
  logic             op_last;
  logic             acc_s;
  logic [EXP_W-1:0] acc_e;
  logic [W:0]       acc_m;

  logic             al_sa, al_sb;
  logic [EXP_W-1:0] al_e;
  logic [W-1:0]     al_a, al_b;

  logic             op_zero, acc_zero;
  logic [W-1:0]     op_m;
  logic [EXP_W-1:0] op_e;
  logic             op_big;
  logic [EXP_W-1:0] diff;
  logic [W-1:0]     sh_in, sh_out;

  logic [W:0]       sum;
  logic             sum_s;

  logic             carry, hid, norm_stay;

  assign op_zero  = (op[14:0] == '0);
  assign acc_zero = (acc_m == '0);
  assign op_m     = {1'b1, op[MANT_W-1:0],
                     {GUARD_BITS{1'b0}}};
  assign op_e     = op[14:10];
  assign op_big   = (op_e > acc_e);
  assign diff     = op_big ? op_e - acc_e
                           : acc_e - op_e;
  assign sh_in    = op_big ? acc_m[W-1:0] : op_m;

  float_align_shift #(.W(W)) u_shift (
    .din  (sh_in),
    .sh   (diff),
    .dout (sh_out)
  );

  // Sign-magnitude add; larger magnitude sets sign.
  always_comb begin
    sum   = '0;
    sum_s = al_sa;
    if (al_sa == al_sb) begin
      sum = {1'b0, al_a} + {1'b0, al_b};
    end else if (al_a >= al_b) begin
      sum = {1'b0, al_a} - {1'b0, al_b};
    end else begin
      sum   = {1'b0, al_b} - {1'b0, al_a};
      sum_s = al_sb;
    end
  end

  assign carry = acc_m[W];
  assign hid   = acc_m[W-1];
  // Keep shifting left only while exponent room remains;
  // at exponent 0 the flush happens on the exit cycle.
  assign norm_stay = !acc_zero && !carry && !hid
                     && (acc_e != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = ALIGN;
      ALIGN: begin
        if (op_zero || acc_zero)
          state_nx = op_last ? OUT : IDLE;
        else
          state_nx = ADD;
      end
      ADD:   state_nx = NORM;
      NORM:  if (!norm_stay)
               state_nx = op_last ? OUT : IDLE;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    out_data  = '0;
    if (state == OUT && !acc_zero)
      out_data = {acc_s, acc_e,
                  acc_m[W-2 -: MANT_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      op_last <= 1'b0;
      acc_s   <= 1'b0;
      acc_e   <= '0;
      acc_m   <= '0;
      al_sa   <= 1'b0;
      al_sb   <= 1'b0;
      al_e    <= '0;
      al_a    <= '0;
      al_b    <= '0;
    end else if (clear) begin
      acc_s <= 1'b0;
      acc_e <= '0;
      acc_m <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op      <= in_data;
            op_last <= in_last;
          end
        end
        ALIGN: begin
          if (op_zero) begin
            acc_m <= acc_m;
          end else if (acc_zero) begin
            acc_s <= op[15];
            acc_e <= op_e;
            acc_m <= {1'b0, op_m};
          end else begin
            al_sa <= acc_s;
            al_sb <= op[15];
            al_e  <= op_big ? op_e : acc_e;
            al_a  <= op_big ? sh_out : acc_m[W-1:0];
            al_b  <= op_big ? op_m : sh_out;
          end
        end
        ADD: begin
          acc_m <= sum;
          acc_s <= (sum == '0) ? 1'b0 : sum_s;
          acc_e <= (sum == '0) ? '0 : al_e;
        end
        NORM: begin
          if (carry) begin
            if (acc_e == '1) begin
              // Overflow pins magnitude at MAX_MAG.
              acc_e <= MAX_MAG[14:10];
              acc_m <= {1'b0, {W{1'b1}}};
            end else begin
              acc_e <= acc_e + 1'b1;
              acc_m <= acc_m >> 1;
            end
          end else if (!acc_zero && !hid) begin
            if (acc_e == '0) begin
              acc_s <= 1'b0;
              acc_m <= '0;
            end else begin
              acc_e <= acc_e - 1'b1;
              acc_m <= acc_m << 1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            acc_s <= 1'b0;
            acc_e <= '0;
            acc_m <= '0;
          end
        end
        default: begin
          acc_m <= acc_m;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_accum.sv
// Randomized and directed bench for float_accum against a value-level model.
// Model keeps the running sum as a signed integer in guard-bit units.
module tb_float_accum;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  float_accum #(.GUARD_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int msb(input longint x);
    for (int i = 62; i >= 0; i--)
      if (x[i]) return i;
    return -1;
  endfunction

  // Sum value: magnitude = mantissa(with 3 guard bits) << exponent.
  function automatic longint madd(input longint acc,
                                  input logic [15:0] d);
    longint ma, mb, s, m;
    int ea, eb, e;
    logic sa, sb;
    if (d[14:0] == 15'h0) return acc;
    mb = longint'({1'b1, d[9:0]}) << (3 + int'(d[14:10]));
    sb = d[15];
    if (acc == 0) return sb ? -mb : mb;
    sa = (acc < 0);
    ma = sa ? -acc : acc;
    ea = msb(ma) - 13;
    eb = int'(d[14:10]);
    e  = (ea > eb) ? ea : eb;
    ma = (ma >> e) << e;
    mb = (mb >> e) << e;
    s  = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (s == 0) return 0;
    m = (s < 0) ? -s : s;
    if (m >= (64'sd1 << (e + 14))) begin
      m = (m >> (e + 1)) << (e + 1);
      if (e + 1 > 31) m = ((64'sd1 << 14) - 1) << 31;
    end else if (msb(m) - 13 < 0) begin
      return 0;
    end
    return (s < 0) ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input longint v);
    longint m;
    int e;
    logic [4:0] ee;
    logic [9:0] mm;
    if (v == 0) return 16'h0000;
    m  = (v < 0) ? -v : v;
    e  = msb(m) - 13;
    ee = e[4:0];
    mm = 10'(m >> (e + 3));
    return {v < 0, ee, mm};
  endfunction

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [15:0] exp,
                      output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] gen();
    int r;
    logic [4:0] e;
    logic [9:0] m;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
    if (r == 1) return 16'($urandom);
    e = 5'($urandom_range(10, 20));
    m = 10'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic pair(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp,
                      output int lat);
    send(a, 1'b0);
    send(b, 1'b1);
    recv(tag, exp, lat);
  endtask

  initial begin
    int lat;
    int nt;
    longint acc;
    logic [15:0] d, hold;

    rst = 1'b1; clear = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    rst = 1'b0;

    pair("sum_1p2", 16'h3C00, 16'h4000, 16'h4200, lat);
    check("lat_noshift", 32'(lat), 32'd3);
    pair("sum_cancel", 16'h3C00, 16'hBC00, 16'h0000, lat);
    pair("sum_tiny", 16'h3C01, 16'hBC00, 16'h1400, lat);
    check("lat_10shift", 32'(lat), 32'd13);
    pair("sum_sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, lat);
    pair("sum_shout", 16'h3C00, 16'h0400, 16'h3C00, lat);

    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    hold = out_data;
    check("bp_first", 32'(hold), 32'h4200);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(hold));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    recv("bp_release", 16'h4200, lat);
    check("bp_after_ready", 32'(in_ready), 32'd1);

    send(16'h3C01, 1'b0);
    send(16'hBC00, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    send(16'h4200, 1'b1);
    recv("clr_single", 16'h4200, lat);

    in_data = 16'h3C00; in_last = 1'b1; in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    check("clr_drop_ready", 32'(in_ready), 32'd1);
    send(16'h4200, 1'b1);
    recv("clr_drop_sum", 16'h4200, lat);

    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    send(16'hC000, 1'b1);
    recv("rst_mid_sum", 16'hC000, lat);

    for (int s = 0; s < 60; s++) begin
      acc = 0;
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        d = gen();
        acc = madd(acc, d);
        send(d, t == nt - 1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      recv("rand_sum", enc(acc), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
